// File: rtl/p405s_logical_pkg.sv
// Shared op-code encodings, condition-code constants and elaboration helpers
// for the pipelined logical unit.
package p405s_logical_pkg;

   localparam logic [3:0] OP_AND     = 4'h0;
   localparam logic [3:0] OP_ANDC    = 4'h1;
   localparam logic [3:0] OP_OR      = 4'h2;
   localparam logic [3:0] OP_ORC     = 4'h3;
   localparam logic [3:0] OP_XOR     = 4'h4;
   localparam logic [3:0] OP_EQV     = 4'h5;
   localparam logic [3:0] OP_NAND    = 4'h6;
   localparam logic [3:0] OP_NOR     = 4'h7;
   localparam logic [3:0] OP_EXTSB   = 4'h8;
   localparam logic [3:0] OP_EXTSH   = 4'h9;
   localparam logic [3:0] OP_CNTLZ   = 4'hA;
   localparam logic [3:0] OP_DLMZB   = 4'hB;
   localparam logic [3:0] OP_POPCNTB = 4'hC;
   localparam logic [3:0] OP_CMPB    = 4'hD;
   localparam logic [3:0] OP_RSV_E   = 4'hE;
   localparam logic [3:0] OP_RSV_F   = 4'hF;

   localparam logic [2:0] CC_LT = 3'b100;
   localparam logic [2:0] CC_GT = 3'b010;
   localparam logic [2:0] CC_EQ = 3'b001;

   function automatic int clog2(input int value);
      int result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) result++;
      return result;
   endfunction

endpackage

// File: rtl/p405s_lzc.sv
// Leading-zero counter: count is WIDTH when the whole vector is zero.
module p405s_lzc
   import p405s_logical_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0]        din,
   output logic [clog2(WIDTH):0]   count,
   output logic                    allZero
);

   localparam int CW = clog2(WIDTH) + 1;

   // NOTE: the default before the loop keeps this purely combinational; the
   // last (most significant) set bit wins, giving the leading-zero count.
   always_comb begin
      count = CW'(WIDTH);
      for (int i = 0; i < WIDTH; i++) begin
         if (din[i]) count = CW'(WIDTH - 1 - i);
      end
   end

   assign allZero = ~|din;

endmodule

// File: rtl/p405s_logical_pipe.sv
// Two-stage logical execute unit with valid/ready handshake, tag sideband
// and flush; stage 1 precomputes bitwise/byte results, stage 2 finishes.
module p405s_logical_pipe
   import p405s_logical_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int TAG_W  = 4
) (
   input  logic              CB,
   input  logic              reset_NEG,
   input  logic              flush,
   input  logic              inValid,
   output logic              inReady,
   input  logic [3:0]        op,
   input  logic [DATA_W-1:0] aBus,
   input  logic [DATA_W-1:0] bBus,
   input  logic [TAG_W-1:0]  tagIn,
   output logic              outValid,
   input  logic              outReady,
   output logic [DATA_W-1:0] result,
   output logic [2:0]        ccBits,
   output logic [TAG_W-1:0]  tagOut,
   output logic              illegalOp
);

   localparam int N = DATA_W / 8;

   logic              s1Valid, s2Valid, s1Advance, accept;
   logic [3:0]        s1Op;
   logic [DATA_W-1:0] s1A, s1Res, preRes;
   logic [TAG_W-1:0]  s1Tag;
   logic [2*N-1:0]    s1Zero, preZero;

   assign s1Advance = s1Valid & (~s2Valid | outReady);
   assign inReady   = ~flush & (~s1Valid | s1Advance);
   assign accept    = inValid & inReady;
   assign outValid  = s2Valid;

   // Zero-flag vector is ordered in DLMZB scan order: A byte 0 at the MSB.
   always_comb begin
      preRes  = '0;
      preZero = '0;
      for (int k = 0; k < N; k++) begin
         preZero[2*N-1-k] = (aBus[DATA_W-1-8*k -: 8] == 8'h00);
         preZero[N-1-k]   = (bBus[DATA_W-1-8*k -: 8] == 8'h00);
      end
      case (op)
         OP_AND:  preRes = aBus & bBus;
         OP_ANDC: preRes = aBus & ~bBus;
         OP_OR:   preRes = aBus | bBus;
         OP_ORC:  preRes = aBus | ~bBus;
         OP_XOR:  preRes = aBus ^ bBus;
         OP_EQV:  preRes = ~(aBus ^ bBus);
         OP_NAND: preRes = ~(aBus & bBus);
         OP_NOR:  preRes = ~(aBus | bBus);
         OP_POPCNTB:
            for (int k = 0; k < N; k++) preRes[8*k +: 8] = 8'($countones(aBus[8*k +: 8]));
         OP_CMPB:
            for (int k = 0; k < N; k++)
               preRes[8*k +: 8] = (aBus[8*k +: 8] == bBus[8*k +: 8]) ? 8'hFF : 8'h00;
         default: preRes = '0;
      endcase
   end

   // NOTE: stage-1 data needs no reset; s1Valid qualifies it and loading only
   // on acceptance keeps the operands quiet while idle.
   always_ff @(posedge CB) begin
      if (accept) begin
         s1Op   <= op;
         s1A    <= aBus;
         s1Tag  <= tagIn;
         s1Res  <= preRes;
         s1Zero <= preZero;
      end
   end

   logic [clog2(DATA_W):0] clzA;
   logic [clog2(2*N):0]    clzZ;
   logic                   aAllZero, zAllZero;

   p405s_lzc #(.WIDTH(DATA_W)) uLzcA (.din(s1A),    .count(clzA), .allZero(aAllZero));
   p405s_lzc #(.WIDTH(2*N))    uLzcZ (.din(s1Zero), .count(clzZ), .allZero(zAllZero));

   logic [DATA_W-1:0] nextRes;
   logic [2:0]        nextCc;
   logic              nextIll;

   always_comb begin
      nextRes = s1Res;
      nextIll = (s1Op == OP_RSV_E) || (s1Op == OP_RSV_F);
      case (s1Op)
         OP_EXTSB: nextRes = {{(DATA_W-8){s1A[7]}}, s1A[7:0]};
         OP_EXTSH: nextRes = {{(DATA_W-16){s1A[15]}}, s1A[15:0]};
         OP_CNTLZ: nextRes = aAllZero ? DATA_W'(DATA_W) : DATA_W'(clzA);
         OP_DLMZB: nextRes = zAllZero ? DATA_W'(2*N) : DATA_W'(int'(clzZ) + 1);
         OP_RSV_E, OP_RSV_F: nextRes = '0;
         default:  nextRes = s1Res;
      endcase
      if (s1Op == OP_DLMZB)
         nextCc = zAllZero ? CC_EQ : ((int'(clzZ) < N) ? CC_GT : CC_LT);
      else
         nextCc = {nextRes[DATA_W-1], ~nextRes[DATA_W-1] & (|nextRes), ~(|nextRes)};
   end

   // NOTE: all sequential state uses non-blocking assignment so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge CB or negedge reset_NEG) begin
      if (!reset_NEG) begin
         s1Valid   <= 1'b0;
         s2Valid   <= 1'b0;
         result    <= '0;
         ccBits    <= 3'b000;
         tagOut    <= '0;
         illegalOp <= 1'b0;
      end else begin
         if (flush)          s1Valid <= 1'b0;
         else if (accept)    s1Valid <= 1'b1;
         else if (s1Advance) s1Valid <= 1'b0;

         if (flush)          s2Valid <= 1'b0;
         else if (s1Advance) s2Valid <= 1'b1;
         else if (outReady)  s2Valid <= 1'b0;

         if (s1Advance) begin
            result    <= nextRes;
            ccBits    <= nextCc;
            tagOut    <= s1Tag;
            illegalOp <= nextIll;
         end
      end
   end

endmodule
